// File: rtl/tlut_matmul_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tlut_matmul_pkg                                              |
// | Description : Shared types and constants for the temporal-LUT matmul       |
// |               job sequencer (state encoding, phase sweep length,           |
// |               performance counter widths).                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package tlut_matmul_pkg;

    // Sequencer states, explicit 3-bit encoding
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        COUNT  = 3'd2,
        DRAIN  = 3'd3,
        RESULT = 3'd4
    } ctrl_state_e;

    localparam int DATA_WIDTH_DEFAULT = 4;
    localparam int PHASE_CYCLES       = 2 ** DATA_WIDTH_DEFAULT;
    localparam int PERF_CYC_W         = 32;
    localparam int PERF_JOB_W         = 16;

    // Length of the temporal sweep for an arbitrary operand width
    function automatic int phase_cycles(input int dw);
        return 2 ** dw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tlut_phase_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tlut_phase_cnt                                               |
// | Description : Loadable up-counter with clear/enable and a terminal-count   |
// |               flag. Priority: rst > clr > load > en.                       |
// | Ports       : clk, rst      clock, synchronous active-high reset           |
// |               clr, load, en counter controls                               |
// |               load_val      value taken on load                            |
// |               term          terminal value compared against cnt            |
// |               cnt           current count                                  |
// |               tc            cnt == term                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tlut_phase_cnt #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic [WIDTH-1:0] term,
    output logic [WIDTH-1:0] cnt,
    output logic             tc
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (en) begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

    assign cnt = r_cnt;
    assign tc  = (r_cnt == term);

endmodule
`default_nettype wire

// File: rtl/tlut_matmul_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tlut_matmul_ctrl                                             |
// | Description : Job sequencer for the temporal-LUT matmul datapath. Per tile |
// |               it clears the TLUT accumulators, sweeps the temporal phase   |
// |               over 2**DATA_WIDTH cycles, waits out the adder-tree latency  |
// |               and holds a result-valid handshake for writeback.            |
// | Ports       : clk, rst                 clock, sync active-high reset       |
// |               start_valid/start_ready  job request handshake               |
// |               cfg_tiles                tile count (latched on start)       |
// |               abort                    synchronous job cancel              |
// |               tlut_clr/tlut_en/tlut_phase  TLUT datapath controls          |
// |               tile_idx                 tile in progress                    |
// |               res_valid/res_ready      per-tile result handshake           |
// |               busy, done               status                              |
// |               perf_busy_cycles, perf_jobs  (only with the macro below)     |
// | Config      : TLUT_CTRL_PERF_CNT_EN adds saturating performance counters.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tlut_matmul_ctrl
    import tlut_matmul_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int ADDER_LAT  = 1,
    parameter int TILE_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic [TILE_W-1:0]     cfg_tiles,
    input  logic                  abort,
    output logic                  tlut_clr,
    output logic                  tlut_en,
    output logic [DATA_WIDTH-1:0] tlut_phase,
    output logic [TILE_W-1:0]     tile_idx,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic                  busy,
    output logic                  done
`ifdef TLUT_CTRL_PERF_CNT_EN
    ,
    output logic [PERF_CYC_W-1:0] perf_busy_cycles,
    output logic [PERF_JOB_W-1:0] perf_jobs
`endif
);

    // Drain counter must hold ADDER_LAT-1; keep at least one bit
    localparam int                    c_DRAIN_W    = (ADDER_LAT > 1) ? $clog2(ADDER_LAT) : 1;
    localparam logic [c_DRAIN_W-1:0]  c_DRAIN_TERM = c_DRAIN_W'(ADDER_LAT - 1);
    localparam logic [DATA_WIDTH-1:0] c_PHASE_TERM = {DATA_WIDTH{1'b1}};

    ctrl_state_e             r_state;
    ctrl_state_e             w_next_state;
    logic [TILE_W-1:0]       r_cfg_tiles;
    logic [TILE_W-1:0]       r_tile_idx;
    logic                    r_done;
    logic [DATA_WIDTH-1:0]   w_phase_cnt;
    logic                    w_phase_tc;
    logic [c_DRAIN_W-1:0]    w_drain_cnt_unused;  // drain wait only needs tc
    logic                    w_drain_tc;
    logic                    w_start_hs;
    logic                    w_res_hs;
    logic                    w_last_tile;
    logic                    w_abort;

    assign w_start_hs  = (r_state == IDLE) && start_valid;
    assign w_res_hs    = (r_state == RESULT) && res_ready;
    assign w_last_tile = (r_tile_idx == r_cfg_tiles - TILE_W'(1));
    assign w_abort     = abort && (r_state != IDLE);

    // Temporal phase sweep: zeroed in CLEAR, advances through COUNT
    tlut_phase_cnt #(
        .WIDTH (DATA_WIDTH)
    ) u_phase_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (r_state == CLEAR),
        .load     (1'b0),
        .load_val ('0),
        .en       (r_state == COUNT),
        .term     (c_PHASE_TERM),
        .cnt      (w_phase_cnt),
        .tc       (w_phase_tc)
    );

    // Adder-tree drain wait: held at zero until DRAIN begins
    tlut_phase_cnt #(
        .WIDTH (c_DRAIN_W)
    ) u_drain_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (r_state != DRAIN),
        .load     (1'b0),
        .load_val ('0),
        .en       (r_state == DRAIN),
        .term     (c_DRAIN_TERM),
        .cnt      (w_drain_cnt_unused),
        .tc       (w_drain_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_start_hs && (cfg_tiles != '0)) w_next_state = CLEAR;
            CLEAR:   w_next_state = COUNT;
            COUNT:   if (w_phase_tc) w_next_state = DRAIN;
            DRAIN:   if (w_drain_tc) w_next_state = RESULT;
            RESULT:  if (res_ready) w_next_state = w_last_tile ? IDLE : CLEAR;
            default: w_next_state = IDLE;
        endcase
        // Abort overrides everything, including a simultaneous result handshake
        if (w_abort) begin
            w_next_state = IDLE;
        end
    end

    // Tile bookkeeping and done pulse; tile_idx returns to 0 whenever the job ends
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg_tiles <= '0;
            r_tile_idx  <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_start_hs) begin
                r_cfg_tiles <= cfg_tiles;
                r_tile_idx  <= '0;
                r_done      <= (cfg_tiles == '0);
            end else if (w_abort) begin
                r_tile_idx <= '0;
            end else if (w_res_hs) begin
                if (w_last_tile) begin
                    r_tile_idx <= '0;
                    r_done     <= 1'b1;
                end else begin
                    r_tile_idx <= r_tile_idx + TILE_W'(1);
                end
            end
        end
    end

    assign start_ready = (r_state == IDLE);
    assign busy        = (r_state != IDLE);
    assign tlut_clr    = (r_state == CLEAR);
    assign tlut_en     = (r_state == COUNT);
    assign tlut_phase  = (r_state == COUNT) ? w_phase_cnt : '0;
    assign res_valid   = (r_state == RESULT);
    assign tile_idx    = r_tile_idx;
    assign done        = r_done;

`ifdef TLUT_CTRL_PERF_CNT_EN
    logic [PERF_CYC_W-1:0] r_perf_busy;
    logic [PERF_JOB_W-1:0] r_perf_jobs;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_busy <= '0;
            r_perf_jobs <= '0;
        end else begin
            if (busy && (r_perf_busy != {PERF_CYC_W{1'b1}})) begin
                r_perf_busy <= r_perf_busy + PERF_CYC_W'(1);
            end
            if (r_done && (r_perf_jobs != {PERF_JOB_W{1'b1}})) begin
                r_perf_jobs <= r_perf_jobs + PERF_JOB_W'(1);
            end
        end
    end

    assign perf_busy_cycles = r_perf_busy;
    assign perf_jobs        = r_perf_jobs;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tlut_matmul_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_tlut_matmul_ctrl                                          |
// | Description : Self-checking bench for tlut_matmul_ctrl. A per-tile        |
// |               timeline model predicts every output each cycle; directed   |
// |               scenarios add hand-computed literal expectations.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_tlut_matmul_ctrl;

    localparam int DW = 4;
    localparam int AL = 1;
    localparam int TW = 8;
    localparam int PC = 1 << DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_valid;
    logic          start_ready;
    logic [TW-1:0] cfg_tiles;
    logic          abort;
    logic          tlut_clr;
    logic          tlut_en;
    logic [DW-1:0] tlut_phase;
    logic [TW-1:0] tile_idx;
    logic          res_valid;
    logic          res_ready;
    logic          busy;
    logic          done;
`ifdef TLUT_CTRL_PERF_CNT_EN
    logic [31:0]   perf_busy_cycles;
    logic [15:0]   perf_jobs;
`endif

    always #5 clk = ~clk;

    tlut_matmul_ctrl #(
        .DATA_WIDTH (DW),
        .ADDER_LAT  (AL),
        .TILE_W     (TW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .cfg_tiles   (cfg_tiles),
        .abort       (abort),
        .tlut_clr    (tlut_clr),
        .tlut_en     (tlut_en),
        .tlut_phase  (tlut_phase),
        .tile_idx    (tile_idx),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .busy        (busy),
        .done        (done)
`ifdef TLUT_CTRL_PERF_CNT_EN
        ,
        .perf_busy_cycles (perf_busy_cycles),
        .perf_jobs        (perf_jobs)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // ---------------- model: job = sequence of tiles, each tile a timeline ----
    // m_t counts cycles since the tile's clear cycle:
    //   0 clear, 1..PC sweep (phase m_t-1), PC+1..PC+AL drain, >=PC+1+AL result
    bit     m_valid = 1'b0;
    bit     m_active;
    int     m_t;
    int     m_tile;
    int     m_tiles;
    bit     m_done;
    bit     m_dn;
    bit     m_rv;
    longint m_busy;
    longint m_jobs;

    always @(posedge clk) begin
        if (rst) begin
            m_valid  = 1'b1;
            m_active = 1'b0;
            m_t      = 0;
            m_tile   = 0;
            m_tiles  = 0;
            m_done   = 1'b0;
            m_busy   = 0;
            m_jobs   = 0;
        end else if (m_valid) begin
            m_dn = 1'b0;
            m_rv = m_active && (m_t >= PC + 1 + AL);
            if (m_active) m_busy++;
            if (!m_active) begin
                if (start_valid) begin
                    if (cfg_tiles == 0) m_dn = 1'b1;
                    else begin
                        m_active = 1'b1;
                        m_t      = 0;
                        m_tile   = 0;
                        m_tiles  = int'(cfg_tiles);
                    end
                end
            end else if (abort) begin
                m_active = 1'b0;
            end else if (m_rv && res_ready) begin
                if (m_tile == m_tiles - 1) begin
                    m_active = 1'b0;
                    m_dn     = 1'b1;
                end else begin
                    m_tile++;
                    m_t = 0;
                end
            end else if (!m_rv) begin
                m_t++;
            end
            m_done = m_dn;
            if (m_dn) m_jobs++;
        end
    end

    // ---------------- per-cycle compare and event monitors -------------------
    int n_done    = 0;
    int n_accept  = 0;
    int tile_mask = 0;

    always @(negedge clk) begin
        if (m_valid) begin
            bit e_en;
            e_en = m_active && (m_t >= 1) && (m_t <= PC);
            check("start_ready", start_ready, !m_active);
            check("busy", busy, m_active);
            check("tlut_clr", tlut_clr, m_active && (m_t == 0));
            check("tlut_en", tlut_en, e_en);
            check("tlut_phase", tlut_phase, e_en ? (m_t - 1) : 0);
            check("res_valid", res_valid, m_active && (m_t >= PC + 1 + AL));
            check("tile_idx", tile_idx, m_active ? m_tile : 0);
            check("done", done, m_done);
`ifdef TLUT_CTRL_PERF_CNT_EN
            check("perf_busy_cycles", perf_busy_cycles, m_busy[31:0]);
            check("perf_jobs", perf_jobs, m_jobs[15:0]);
`endif
            if (done) n_done++;
            if (start_valid && start_ready) n_accept++;
            if (res_valid && res_ready) tile_mask |= (1 << tile_idx);
        end
    end

    // ---------------- directed stimulus --------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 500 && busy; i++) step();
        check(nm, busy, 1'b0);
    endtask

    int d0;
    int a0;

    initial begin
        rst = 1'b1; start_valid = 1'b0; cfg_tiles = '0; abort = 1'b0; res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_start_ready", start_ready, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        step();

        // 1) single tile, literal cycle positions relative to the accept cycle
        d0 = n_done;
        start_valid = 1'b1; cfg_tiles = 8'd1;
        step();
        start_valid = 1'b0;
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk);
            check($sformatf("t1_clr_c%0d", k), tlut_clr, k == 1);
            check($sformatf("t1_en_c%0d", k), tlut_en, (k >= 2) && (k <= 17));
            check($sformatf("t1_resv_c%0d", k), res_valid, k == 19);
            check($sformatf("t1_done_c%0d", k), done, k == 20);
            if (k == 2)  check("t1_phase_first", tlut_phase, 0);
            if (k == 17) check("t1_phase_last", tlut_phase, 15);
            step();
        end
        check("t1_done_count", n_done - d0, 1);
`ifdef TLUT_CTRL_PERF_CNT_EN
        check("t1_perf_jobs", perf_jobs, 1);
`endif

        // 2) three tiles, writeback stalls 5 cycles on tile 1
        d0 = n_done; tile_mask = 0;
        start_valid = 1'b1; cfg_tiles = 8'd3;
        step();
        start_valid = 1'b0;
        for (int i = 0; i < 200 && tile_idx != 1; i++) step();
        check("t2_reach_tile1", tile_idx, 1);
        res_ready = 1'b0;
        for (int i = 0; i < 200 && !res_valid; i++) step();
        check("t2_resv_up", res_valid, 1'b1);
        repeat (5) begin
            @(negedge clk);
            check("t2_resv_held", res_valid, 1'b1);
            check("t2_tile_held", tile_idx, 1);
            step();
        end
        res_ready = 1'b1;
        wait_idle("t2_finish");
        step();
        check("t2_tiles_seen", tile_mask, 7);
        check("t2_done_count", n_done - d0, 1);

        // 3) abort in cycle 10, restart in cycle 11
        d0 = n_done;
        start_valid = 1'b1; cfg_tiles = 8'd2;
        step();
        start_valid = 1'b0;
        repeat (9) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        start_valid = 1'b1; cfg_tiles = 8'd1;
        @(negedge clk);
        check("t3_busy_c11", busy, 1'b0);
        check("t3_en_c11", tlut_en, 1'b0);
        check("t3_ready_c11", start_ready, 1'b1);
        step();
        start_valid = 1'b0;
        @(negedge clk);
        check("t3_restart_clr", tlut_clr, 1'b1);
        check("t3_no_done", n_done - d0, 0);
        wait_idle("t3_finish");
        step();

        // 4) zero-tile job
        d0 = n_done;
        start_valid = 1'b1; cfg_tiles = 8'd0;
        step();
        start_valid = 1'b0;
        @(negedge clk);
        check("t4_done", done, 1'b1);
        check("t4_busy", busy, 1'b0);
        repeat (4) step();
        check("t4_done_count", n_done - d0, 1);

        // 5) start held through a 2-tile job
        a0 = n_accept;
        start_valid = 1'b1; cfg_tiles = 8'd2;
        step();
        for (int i = 0; i < 200 && !done; i++) step();
        check("t5_done_seen", done, 1'b1);
        check("t5_one_accept", n_accept - a0, 1);
        check("t5_ready_at_done", start_ready, 1'b1);
        step();
        start_valid = 1'b0;
        check("t5_second_job_clr", tlut_clr, 1'b1);
        wait_idle("t5_finish");
        step();

        // 6) abort coincident with a result handshake
        d0 = n_done;
        start_valid = 1'b1; cfg_tiles = 8'd2;
        step();
        start_valid = 1'b0;
        for (int i = 0; i < 200 && !res_valid; i++) step();
        check("t6_resv_up", res_valid, 1'b1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t6_idle", busy, 1'b0);
        check("t6_tile_reset", tile_idx, 0);
        step();
        check("t6_no_done", n_done - d0, 0);

        // 7) reset mid-job, then a clean job
        start_valid = 1'b1; cfg_tiles = 8'd1;
        step();
        start_valid = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t7_after_rst_busy", busy, 1'b0);
        start_valid = 1'b1; cfg_tiles = 8'd2;
        step();
        start_valid = 1'b0;
        wait_idle("t7_finish");
        repeat (2) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
